// File: rtl/serial_arith_pkg.sv
// Shared mode codes, FSM state encoding and carry-seed helper for the serial arithmetic unit.
package serial_arith_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ADD  = 2'b10;
  localparam logic [1:0] MODE_SUB  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // NEG and SUB form a two's complement, so they start with the +1 already in the carry.
  function automatic logic carry_init(input logic [1:0] m);
    return (m == MODE_NEG) || (m == MODE_SUB);
  endfunction

endpackage

// File: rtl/serial_full_adder.sv
// One-bit combinational full adder used as the serial datapath core.
module serial_full_adder (
  input  logic i_x,
  input  logic i_y,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_x ^ i_y ^ i_cin;
  assign o_cout = (i_x & i_y) | (i_cin & (i_x ^ i_y));

endmodule

// File: rtl/serial_arith_unit.sv
// LSB-first bit-serial PASS/NEG/ADD/SUB unit with word framing, stall, done strobe and flags.
// state | meaning
// IDLE  | no word in progress; start&bit_valid loads bit 0
// RUN   | bits 1..WIDTH-1 outstanding; bit_valid advances, start&bit_valid restarts
module serial_arith_unit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       bit_valid,
  input  logic       bit_a,
  input  logic       bit_b,
  output logic       bit_out,
  output logic       out_valid,
  output logic       busy,
  output logic       done,
  output logic       carry_out,
  output logic       overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic             r_carry;
  logic             r_bit_out, r_out_valid, r_busy, r_done, r_carry_out, r_overflow;

  logic       w_accept_start, w_bit_en, w_last;
  logic [1:0] w_mode;
  logic       w_x, w_y, w_cin, w_sum, w_cout;

  assign w_accept_start = start & bit_valid;
  assign w_bit_en       = bit_valid & (start | (r_state == ST_RUN));
  assign w_last         = bit_valid & ~start & (r_state == ST_RUN) & (r_cnt == CNT_LAST);
  // Bit 0 must use the mode on the port; the latched copy is only valid from bit 1 on.
  assign w_mode         = w_accept_start ? mode : r_mode;
  assign w_cin          = w_accept_start ? carry_init(mode) : r_carry;

  always_comb begin
    w_x = bit_a;
    w_y = 1'b0;
    case (w_mode)
      MODE_NEG: begin
        w_x = 1'b0;
        w_y = ~bit_a;
      end
      MODE_ADD: w_y = bit_b;
      MODE_SUB: w_y = ~bit_b;
      default:  w_y = 1'b0;
    endcase
  end

  serial_full_adder u_fa (
    .i_x   (w_x),
    .i_y   (w_y),
    .i_cin (w_cin),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept_start) begin
      w_state_nxt = ST_RUN;
    end else if (w_last) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_mode      <= MODE_PASS;
      r_carry     <= 1'b0;
      r_bit_out   <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_bit_en;
      r_done      <= w_last;
      r_busy      <= (w_state_nxt == ST_RUN);
      if (w_bit_en) begin
        r_bit_out <= w_sum;
        r_carry   <= w_cout;
        if (w_accept_start) begin
          r_cnt <= CNT_W'(1);
        end else if (w_last) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (w_accept_start) begin
        r_mode      <= mode;
        r_carry_out <= 1'b0;
        r_overflow  <= 1'b0;
      end else if (w_last) begin
        r_carry_out <= w_cout;
        r_overflow  <= w_cin ^ w_cout;
      end
    end
  end

  assign bit_out   = r_bit_out;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule
